// File: rtl/mem_info_gen.sv
// MEM-stage controller: drives the data-SRAM handshake for loads/stores and
// publishes the {w_data, w_addr, w_en, finish} forwarding bundle to ID.
module mem_info_gen #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int INFO_W = DATA_W + REG_AW + 2
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              ex_valid,
  output logic              ms_allowin,
  input  logic [2:0]        ex_op,
  input  logic [1:0]        ex_size,
  input  logic [DATA_W-1:0] ex_addr,
  input  logic [DATA_W-1:0] ex_st_data,
  input  logic [REG_AW-1:0] ex_w_addr,
  input  logic              ex_w_en,
  input  logic              flush,
  output logic              req,
  output logic              wr,
  output logic [1:0]        size,
  output logic [3:0]        wstrb,
  output logic [DATA_W-1:0] addr,
  output logic [DATA_W-1:0] wdata,
  input  logic              addr_ok,
  input  logic              data_ok,
  input  logic [DATA_W-1:0] rdata,
  output logic              ms_valid,
  input  logic              wb_allowin,
  output logic [INFO_W-1:0] info_data_mem
);

  localparam logic [2:0] OP_NONE = 3'd0;
  localparam logic [2:0] OP_LDW  = 3'd1;
  localparam logic [2:0] OP_LDB  = 3'd2;
  localparam logic [2:0] OP_LDBU = 3'd3;
  localparam logic [2:0] OP_LDH  = 3'd4;
  localparam logic [2:0] OP_LDHU = 3'd5;
  localparam logic [2:0] OP_STW  = 3'd6;
  localparam logic [2:0] OP_ST   = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_DONE  = 3'd3,
    S_DRAIN = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [2:0]          op_q, op_d;
  logic [DATA_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [3:0]          wstrb_q, wstrb_d;
  logic [1:0]          size_q, size_d;
  logic                wr_q, wr_d;
  logic [REG_AW-1:0]   w_addr_q, w_addr_d;
  logic                w_en_q, w_en_d;
  logic [DATA_W-1:0]   w_data_q, w_data_d;

  logic                accept;
  logic                is_store;
  logic [1:0]          st_size;
  logic [1:0]          mem_size;
  logic [DATA_W-1:0]   resp_data;
  logic                finish;

  function automatic logic [DATA_W-1:0] load_extract(input logic [2:0]        op,
                                                     input logic [1:0]        ofs,
                                                     input logic [DATA_W-1:0] rd);
    logic [7:0]  b;
    logic [15:0] h;
    b = rd[{ofs, 3'b000} +: 8];
    h = rd[{ofs[1], 4'b0000} +: 16];
    case (op)
      OP_LDB:  load_extract = {{(DATA_W-8){b[7]}}, b};
      OP_LDBU: load_extract = {{(DATA_W-8){1'b0}}, b};
      OP_LDH:  load_extract = {{(DATA_W-16){h[15]}}, h};
      OP_LDHU: load_extract = {{(DATA_W-16){1'b0}}, h};
      default: load_extract = rd;
    endcase
  endfunction

  function automatic logic [3:0] store_wstrb(input logic [1:0] sz, input logic [1:0] ofs);
    case (sz)
      2'd0:    store_wstrb = 4'b0001 << ofs;
      2'd1:    store_wstrb = 4'b0011 << ofs;
      default: store_wstrb = 4'hF;
    endcase
  endfunction

  function automatic logic [DATA_W-1:0] store_wdata(input logic [1:0] sz,
                                                    input logic [DATA_W-1:0] d);
    case (sz)
      2'd0:    store_wdata = {(DATA_W/8){d[7:0]}};
      2'd1:    store_wdata = {(DATA_W/16){d[15:0]}};
      default: store_wdata = d;
    endcase
  endfunction

  assign ms_allowin = (state_q == S_IDLE) || ((state_q == S_DONE) && wb_allowin);
  assign accept     = ex_valid && ms_allowin && !flush;
  assign is_store   = (ex_op == OP_STW) || (ex_op == OP_ST);

  // An out-of-range store size (3) is treated as a word access.
  assign st_size = ((ex_op == OP_STW) || (ex_size == 2'd3)) ? 2'd2 : ex_size;

  always_comb begin
    mem_size = 2'd2;
    case (ex_op)
      OP_LDB, OP_LDBU: mem_size = 2'd0;
      OP_LDH, OP_LDHU: mem_size = 2'd1;
      OP_STW, OP_ST:   mem_size = st_size;
      default:         mem_size = 2'd2;
    endcase
  end

  assign resp_data = wr_q ? '0 : load_extract(op_q, addr_q[1:0], rdata);

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    wstrb_d  = wstrb_q;
    size_d   = size_q;
    wr_d     = wr_q;
    w_addr_d = w_addr_q;
    w_en_d   = w_en_q;
    w_data_d = w_data_q;

    case (state_q)
      S_REQ: begin
        if (flush) begin
          // A same-cycle response means nothing remains outstanding to swallow.
          if (addr_ok && !data_ok) begin
            state_d = S_DRAIN;
            w_en_d  = 1'b0;
          end else begin
            state_d = S_IDLE;
          end
        end else if (addr_ok) begin
          if (data_ok) begin
            state_d  = S_DONE;
            w_data_d = resp_data;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (flush) begin
          state_d = data_ok ? S_IDLE : S_DRAIN;
          w_en_d  = 1'b0;
        end else if (data_ok) begin
          state_d  = S_DONE;
          w_data_d = resp_data;
        end
      end
      S_DONE: begin
        if (flush || wb_allowin) state_d = S_IDLE;
      end
      S_DRAIN: begin
        if (data_ok) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (accept) begin
      state_d  = (ex_op == OP_NONE) ? S_DONE : S_REQ;
      op_d     = ex_op;
      addr_d   = ex_addr;
      w_addr_d = ex_w_addr;
      w_en_d   = ex_w_en && !is_store;
      wr_d     = is_store;
      size_d   = mem_size;
      wstrb_d  = is_store ? store_wstrb(st_size, ex_addr[1:0]) : 4'h0;
      wdata_d  = is_store ? store_wdata(st_size, ex_st_data) : '0;
      w_data_d = (ex_op == OP_NONE) ? ex_addr : '0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      size_q   <= '0;
      wr_q     <= 1'b0;
      w_addr_q <= '0;
      w_en_q   <= 1'b0;
      w_data_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      wstrb_q  <= wstrb_d;
      size_q   <= size_d;
      wr_q     <= wr_d;
      w_addr_q <= w_addr_d;
      w_en_q   <= w_en_d;
      w_data_q <= w_data_d;
    end
  end

  // Request-side outputs are gated so they read zero outside REQ.
  assign req    = (state_q == S_REQ);
  assign wr     = req && wr_q;
  assign size   = req ? size_q : 2'd0;
  assign wstrb  = req ? wstrb_q : 4'h0;
  assign addr   = req ? addr_q : '0;
  assign wdata  = req ? wdata_q : '0;

  assign ms_valid = (state_q == S_DONE);
  assign finish   = (state_q == S_DONE);

  assign info_data_mem = (state_q == S_IDLE) ? '0
                       : {(finish ? w_data_q : {DATA_W{1'b0}}), w_addr_q, w_en_q, finish};

endmodule

// File: tb/tb_mem_info_gen.sv
// Self-checking bench for mem_info_gen: directed vector table, corner-case
// sequences, and randomized transactions against a behavioural model.
module tb_mem_info_gen;

  logic        clk = 1'b0;
  logic        rstn;
  logic        ex_valid;
  logic        ms_allowin;
  logic [2:0]  ex_op;
  logic [1:0]  ex_size;
  logic [31:0] ex_addr;
  logic [31:0] ex_st_data;
  logic [4:0]  ex_w_addr;
  logic        ex_w_en;
  logic        flush;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [3:0]  wstrb;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;
  logic        ms_valid;
  logic        wb_allowin;
  logic [38:0] info_data_mem;

  int n_chk  = 0;
  int n_fail = 0;

  mem_info_gen dut (
    .clk(clk), .rstn(rstn), .ex_valid(ex_valid), .ms_allowin(ms_allowin),
    .ex_op(ex_op), .ex_size(ex_size), .ex_addr(ex_addr), .ex_st_data(ex_st_data),
    .ex_w_addr(ex_w_addr), .ex_w_en(ex_w_en), .flush(flush),
    .req(req), .wr(wr), .size(size), .wstrb(wstrb), .addr(addr), .wdata(wdata),
    .addr_ok(addr_ok), .data_ok(data_ok), .rdata(rdata),
    .ms_valid(ms_valid), .wb_allowin(wb_allowin), .info_data_mem(info_data_mem)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Reference model: byte lanes and extension computed arithmetically.
  function automatic logic [1:0] m_size(input logic [2:0] op, input logic [1:0] sz);
    case (op)
      3'd2, 3'd3: return 2'd0;
      3'd4, 3'd5: return 2'd1;
      3'd7:       return sz;
      default:    return 2'd2;
    endcase
  endfunction

  function automatic logic [3:0] m_wstrb(input logic [2:0] op, input logic [1:0] sz, input logic [31:0] a);
    int nbytes, v;
    if (op < 3'd6) return 4'h0;
    nbytes = 1 << m_size(op, sz);
    if (nbytes == 4) return 4'hF;
    v = ((1 << nbytes) - 1) << (a % 4);
    return v[3:0];
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] op, input logic [1:0] sz, input logic [31:0] d);
    int nbits;
    longint unit, r;
    nbits = 8 << m_size(op, sz);
    if (nbits == 32) return d;
    unit = longint'(d) % (longint'(1) << nbits);
    r = 0;
    for (int k = 0; k < 32 / nbits; k++) r += unit << (nbits * k);
    return r[31:0];
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] op, input logic [31:0] a, input logic [31:0] rd);
    int unsigned ofs;
    longint v;
    ofs = a % 4;
    case (op)
      3'd2, 3'd3: begin
        v = longint'((rd >> (8 * ofs)) % 256);
        if (op == 3'd2 && v >= 128) v -= 256;
      end
      3'd4, 3'd5: begin
        v = longint'((rd >> (16 * (ofs / 2))) % 65536);
        if (op == 3'd4 && v >= 32768) v -= 65536;
      end
      default: v = longint'(rd);
    endcase
    return v[31:0];
  endfunction

  task automatic run_txn(input logic [2:0] op, input logic [1:0] sz, input logic [31:0] a,
                         input logic [31:0] sd, input logic [4:0] wa, input logic we,
                         input logic [31:0] rd, input int alat, input int dlat, input int wlat,
                         input logic [3:0] e_wstrb, input logic [31:0] e_wdata, input logic [1:0] e_size,
                         input logic e_wr, input logic [31:0] e_wd, input logic e_wen);
    logic [38:0] pend, fin;
    pend = {32'h0, wa, e_wen, 1'b0};
    fin  = {e_wd, wa, e_wen, 1'b1};
    ex_op = op; ex_size = sz; ex_addr = a; ex_st_data = sd;
    ex_w_addr = wa; ex_w_en = we; ex_valid = 1'b1;
    wb_allowin = 1'b0; addr_ok = 1'b0; data_ok = 1'b0;
    #1 chk("accept_allowin", 64'(ms_allowin), 64'd1);
    tick();
    ex_valid = 1'b0;
    if (op != 3'd0) begin
      for (int i = 0; i <= alat; i++) begin
        if (i == alat) begin
          addr_ok = 1'b1;
          if (dlat == 0) begin data_ok = 1'b1; rdata = rd; end
        end
        #1;
        chk("req", 64'(req), 64'd1);
        chk("wr", 64'(wr), 64'(e_wr));
        chk("size", 64'(size), 64'(e_size));
        chk("wstrb", 64'(wstrb), 64'(e_wstrb));
        chk("addr", 64'(addr), 64'(a));
        if (e_wr) chk("wdata", 64'(wdata), 64'(e_wdata));
        chk("pend_info", 64'(info_data_mem), 64'(pend));
        chk("busy_allowin", 64'(ms_allowin), 64'd0);
        tick();
      end
      addr_ok = 1'b0; data_ok = 1'b0;
      for (int i = 1; i <= dlat; i++) begin
        if (i == dlat) begin data_ok = 1'b1; rdata = rd; end
        #1;
        chk("wait_req", 64'(req), 64'd0);
        chk("wait_info", 64'(info_data_mem), 64'(pend));
        chk("wait_valid", 64'(ms_valid), 64'd0);
        tick();
      end
      data_ok = 1'b0;
      rdata = $urandom;
    end
    for (int i = 0; i <= wlat; i++) begin
      if (i == wlat) wb_allowin = 1'b1;
      #1;
      chk("done_valid", 64'(ms_valid), 64'd1);
      if (e_wr) chk("done_info_st", 64'(info_data_mem[6:0]), 64'(fin[6:0]));
      else      chk("done_info", 64'(info_data_mem), 64'(fin));
      chk("done_allowin", 64'(ms_allowin), 64'(i == wlat));
      tick();
    end
    wb_allowin = 1'b0;
    #1;
    chk("idle_valid", 64'(ms_valid), 64'd0);
    chk("idle_info", 64'(info_data_mem), 64'd0);
  endtask

  task automatic run_model(input logic [2:0] op, input logic [1:0] sz, input logic [31:0] a,
                           input logic [31:0] sd, input logic [4:0] wa, input logic we,
                           input logic [31:0] rd, input int alat, input int dlat, input int wlat);
    logic st;
    logic [31:0] wd;
    st = (op >= 3'd6);
    wd = (op == 3'd0) ? a : (st ? 32'h0 : m_load(op, a, rd));
    run_txn(op, sz, a, sd, wa, we, rd, alat, dlat, wlat,
            m_wstrb(op, sz, a), m_wdata(op, sz, sd), m_size(op, sz), st, wd, we && !st);
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [1:0]  sz;
    logic [31:0] a;
    logic [31:0] sd;
    logic [4:0]  wa;
    logic        we;
    logic [31:0] rd;
    int          alat;
    int          dlat;
    logic [3:0]  e_wstrb;
    logic [31:0] e_wdata;
    logic [1:0]  e_size;
    logic        e_wr;
    logic [31:0] e_wd;
    logic        e_wen;
  } vec_t;

  vec_t tbl[9];

  initial begin
    tbl[0] = '{3'd2, 2'd0, 32'h0000_1003, 32'h0, 5'd3, 1'b1, 32'h80FF_FFFF, 1, 2, 4'h0, 32'h0, 2'd0, 1'b0, 32'hFFFF_FF80, 1'b1};
    tbl[1] = '{3'd3, 2'd0, 32'h0000_1001, 32'h0, 5'd4, 1'b1, 32'h1234_A578, 0, 1, 4'h0, 32'h0, 2'd0, 1'b0, 32'h0000_00A5, 1'b1};
    tbl[2] = '{3'd4, 2'd0, 32'h0000_2002, 32'h0, 5'd6, 1'b1, 32'h8001_7FFF, 0, 0, 4'h0, 32'h0, 2'd1, 1'b0, 32'hFFFF_8001, 1'b1};
    tbl[3] = '{3'd5, 2'd0, 32'h0000_2000, 32'h0, 5'd7, 1'b1, 32'h8001_F00D, 2, 1, 4'h0, 32'h0, 2'd1, 1'b0, 32'h0000_F00D, 1'b1};
    tbl[4] = '{3'd1, 2'd0, 32'h0000_3000, 32'h0, 5'd8, 1'b1, 32'hDEAD_BEEF, 0, 3, 4'h0, 32'h0, 2'd2, 1'b0, 32'hDEAD_BEEF, 1'b1};
    tbl[5] = '{3'd7, 2'd1, 32'h0000_4002, 32'h0000_ABCD, 5'd9, 1'b1, 32'h0, 3, 1, 4'b1100, 32'hABCD_ABCD, 2'd1, 1'b1, 32'h0, 1'b0};
    tbl[6] = '{3'd7, 2'd0, 32'h0000_4001, 32'h1234_5677, 5'd10, 1'b1, 32'h0, 0, 1, 4'b0010, 32'h7777_7777, 2'd0, 1'b1, 32'h0, 1'b0};
    tbl[7] = '{3'd6, 2'd0, 32'h0000_4000, 32'hCAFE_F00D, 5'd11, 1'b0, 32'h0, 1, 2, 4'hF, 32'hCAFE_F00D, 2'd2, 1'b1, 32'h0, 1'b0};
    tbl[8] = '{3'd0, 2'd0, 32'h0000_1234, 32'h0, 5'd5, 1'b1, 32'h0, 0, 0, 4'h0, 32'h0, 2'd0, 1'b0, 32'h0000_1234, 1'b1};

    rstn = 1'b0; ex_valid = 1'b0; ex_op = 3'd0; ex_size = 2'd0; ex_addr = 32'h0;
    ex_st_data = 32'h0; ex_w_addr = 5'd0; ex_w_en = 1'b0; flush = 1'b0;
    addr_ok = 1'b0; data_ok = 1'b0; rdata = 32'h0; wb_allowin = 1'b0;
    tick(); tick();
    chk("rst_allowin", 64'(ms_allowin), 64'd1);
    chk("rst_req", 64'(req), 64'd0);
    chk("rst_valid", 64'(ms_valid), 64'd0);
    chk("rst_info", 64'(info_data_mem), 64'd0);
    rstn = 1'b1;
    tick();

    foreach (tbl[i])
      run_txn(tbl[i].op, tbl[i].sz, tbl[i].a, tbl[i].sd, tbl[i].wa, tbl[i].we, tbl[i].rd,
              tbl[i].alat, tbl[i].dlat, i % 2, tbl[i].e_wstrb, tbl[i].e_wdata, tbl[i].e_size,
              tbl[i].e_wr, tbl[i].e_wd, tbl[i].e_wen);

    // Back-to-back: DONE with wb_allowin accepts the next op without a bubble.
    ex_op = 3'd0; ex_addr = 32'h1234; ex_w_addr = 5'd5; ex_w_en = 1'b1; ex_valid = 1'b1;
    tick();
    ex_valid = 1'b0;
    #1 chk("b2b_first_info", 64'(info_data_mem), 64'({32'h1234, 5'd5, 1'b1, 1'b1}));
    chk("b2b_hold_allowin", 64'(ms_allowin), 64'd0);
    ex_addr = 32'h5678; ex_w_addr = 5'd7; ex_w_en = 1'b0; ex_valid = 1'b1; wb_allowin = 1'b1;
    #1 chk("b2b_allowin", 64'(ms_allowin), 64'd1);
    tick();
    ex_valid = 1'b0; wb_allowin = 1'b0;
    #1 chk("b2b_valid", 64'(ms_valid), 64'd1);
    chk("b2b_second_info", 64'(info_data_mem), 64'({32'h5678, 5'd7, 1'b0, 1'b1}));
    wb_allowin = 1'b1;
    tick();
    wb_allowin = 1'b0;
    #1 chk("b2b_drain_valid", 64'(ms_valid), 64'd0);

    // Flush in WAIT: DRAIN swallows the late response.
    ex_op = 3'd1; ex_addr = 32'h0000_0040; ex_w_addr = 5'd12; ex_w_en = 1'b1; ex_valid = 1'b1;
    tick();
    ex_valid = 1'b0; addr_ok = 1'b1;
    tick();
    addr_ok = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0;
    for (int i = 0; i < 2; i++) begin
      if (i == 1) begin data_ok = 1'b1; rdata = 32'h5555_AAAA; end
      #1;
      chk("drain_wen", 64'(info_data_mem[1]), 64'd0);
      chk("drain_finish", 64'(info_data_mem[0]), 64'd0);
      chk("drain_valid", 64'(ms_valid), 64'd0);
      chk("drain_allowin", 64'(ms_allowin), 64'd0);
      tick();
    end
    data_ok = 1'b0;
    #1 chk("drain_idle_allowin", 64'(ms_allowin), 64'd1);
    chk("drain_idle_valid", 64'(ms_valid), 64'd0);
    chk("drain_idle_info", 64'(info_data_mem), 64'd0);

    // Flush in REQ before addr_ok drops the request immediately.
    ex_op = 3'd2; ex_addr = 32'h0000_0050; ex_valid = 1'b1;
    tick();
    ex_valid = 1'b0; flush = 1'b1;
    #1 chk("flreq_req_before", 64'(req), 64'd1);
    tick();
    flush = 1'b0;
    #1 chk("flreq_req", 64'(req), 64'd0);
    chk("flreq_allowin", 64'(ms_allowin), 64'd1);

    // Flush beats a same-cycle acceptance.
    ex_op = 3'd1; ex_valid = 1'b1; flush = 1'b1;
    tick();
    ex_valid = 1'b0; flush = 1'b0;
    #1 chk("flacc_req", 64'(req), 64'd0);
    chk("flacc_valid", 64'(ms_valid), 64'd0);

    // Asynchronous reset while waiting for data.
    ex_op = 3'd1; ex_addr = 32'h0000_0060; ex_w_addr = 5'd13; ex_w_en = 1'b1; ex_valid = 1'b1;
    tick();
    ex_valid = 1'b0; addr_ok = 1'b1;
    tick();
    addr_ok = 1'b0;
    #1 chk("arst_pre_info", 64'(info_data_mem), 64'({32'h0, 5'd13, 1'b1, 1'b0}));
    rstn = 1'b0;
    #1;
    chk("arst_info", 64'(info_data_mem), 64'd0);
    chk("arst_allowin", 64'(ms_allowin), 64'd1);
    chk("arst_req", 64'(req), 64'd0);
    chk("arst_valid", 64'(ms_valid), 64'd0);
    tick();
    rstn = 1'b1;
    tick();
    run_model(3'd4, 2'd0, 32'h0000_0072, 32'h0, 5'd14, 1'b1, 32'h9ABC_1234, 0, 1, 0);

    // Randomized transactions.
    for (int n = 0; n < 60; n++) begin
      logic [2:0] op;
      op = 3'($urandom_range(0, 7));
      run_model(op, 2'($urandom_range(0, 2)), $urandom, $urandom, 5'($urandom),
                1'($urandom), $urandom, $urandom_range(0, 3), $urandom_range(0, 3),
                $urandom_range(0, 2));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
